// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone arbiter with round-robin grant,
// whole-cyc grant hold and a stall watchdog that ends hung transfers.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [1:0]  m_cyc_i,
    input  logic [1:0]  m_stb_i,
    input  logic [1:0]  m_we_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:0] m_adr_i,
    input  logic [63:0] m_dat_i,
    output logic [1:0]  m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_g;
    logic        r_last;
    logic [15:0] r_cnt;

    logic [1:0]  w_req;
    logic [1:0]  w_gvec;
    logic        w_cyc_g;
    logic        w_stb_g;
    logic        w_we_g;
    logic [3:0]  w_sel_g;
    logic [31:0] w_adr_g;
    logic [31:0] w_dat_g;
    logic        w_stall;
    logic        w_tmo;

    assign w_req   = m_cyc_i & m_stb_i;
    assign w_gvec  = {r_g, ~r_g};
    assign w_cyc_g = r_g ? m_cyc_i[1] : m_cyc_i[0];
    assign w_stb_g = r_g ? m_stb_i[1] : m_stb_i[0];
    assign w_we_g  = r_g ? m_we_i[1]  : m_we_i[0];
    assign w_sel_g = r_g ? m_sel_i[7:4]   : m_sel_i[3:0];
    assign w_adr_g = r_g ? m_adr_i[63:32] : m_adr_i[31:0];
    assign w_dat_g = r_g ? m_dat_i[63:32] : m_dat_i[31:0];

    // An ack in the final stalled cycle suppresses the timeout.
    assign w_stall = (r_state == ST_GRANT) & w_stb_g & ~s_ack_i;
    assign w_tmo   = w_stall & (r_cnt == LP_CNT_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_g     <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_req == 2'b11) begin
                        r_g     <= ~r_last;
                        r_state <= ST_GRANT;
                    end else if (w_req[0]) begin
                        r_g     <= 1'b0;
                        r_state <= ST_GRANT;
                    end else if (w_req[1]) begin
                        r_g     <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_cyc_g) begin
                        r_last  <= r_g;
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_state <= ST_ERR;
                        r_cnt   <= '0;
                    end else if (w_stall) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_ERR: begin
                    r_cnt <= '0;
                    if (w_cyc_g) begin
                        r_state <= ST_GRANT;
                    end else begin
                        r_last  <= r_g;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_ack_o   = '0;
        m_dat_o   = '0;
        grant_o   = '0;
        timeout_o = 1'b0;
        unique case (r_state)
            ST_GRANT: begin
                grant_o = w_gvec;
                s_cyc_o = w_cyc_g;
                s_stb_o = w_stb_g;
                s_we_o  = w_we_g;
                s_sel_o = w_sel_g;
                s_adr_o = w_adr_g;
                s_dat_o = w_dat_g;
                m_ack_o = w_gvec & {2{s_ack_i}};
                m_dat_o = s_dat_i;
            end
            ST_ERR: begin
                grant_o   = w_gvec;
                m_ack_o   = w_gvec;
                m_dat_o   = ERR_DATA;
                timeout_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_wb_arbiter_2m;

    localparam int          TMO  = 8;
    localparam logic [31:0] EDAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cyc, stb, we;
    logic [7:0]  sel;
    logic [63:0] adr, wdat;
    logic        sack;
    logic [31:0] sdat;
    logic [1:0]  ack;
    logic [31:0] rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat;
    logic [1:0]  grant;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus (-1 = nobody), whether this cycle is an
    // error termination, who was served last, and stalled-cycle count.
    int   mo_owner = -1;
    bit   mo_err   = 1'b0;
    int   mo_last  = 1;
    int   mo_stall = 0;
    bit   mchk     = 1'b0;
    logic [1:0] exp_ack;

    wb_arbiter_2m #(.TIMEOUT(TMO), .ERR_DATA(EDAT)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel),
        .m_adr_i(adr), .m_dat_i(wdat),
        .m_ack_o(ack), .m_dat_o(rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat),
        .s_ack_i(sack), .s_dat_i(sdat),
        .grant_o(grant), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int n;
        exp_ack = 2'b00;
        if (mo_owner < 0) begin
            chk("m_grant", 32'(grant), 0);
            chk("m_ack", 32'(ack), 0);
            chk("m_to", 32'(tmo), 0);
            chk("m_scyc", 32'(s_cyc), 0);
            chk("m_sstb", 32'(s_stb), 0);
            chk("m_swe", 32'(s_we), 0);
            chk("m_ssel", 32'(s_sel), 0);
            chk("m_sadr", s_adr, 0);
            chk("m_sdat", s_dat, 0);
        end else begin
            n = mo_owner;
            chk("m_grant", 32'(grant), 32'(1 << n));
            if (mo_err) begin
                exp_ack = 2'(1 << n);
                chk("m_ack", 32'(ack), 32'(exp_ack));
                chk("m_errdat", rdat, EDAT);
                chk("m_to", 32'(tmo), 1);
                chk("m_scyc", 32'(s_cyc), 0);
                chk("m_sstb", 32'(s_stb), 0);
            end else begin
                exp_ack = sack ? 2'(1 << n) : 2'b00;
                chk("m_ack", 32'(ack), 32'(exp_ack));
                chk("m_to", 32'(tmo), 0);
                chk("m_scyc", 32'(s_cyc), 32'(cyc[n]));
                chk("m_sstb", 32'(s_stb), 32'(stb[n]));
                chk("m_swe", 32'(s_we), 32'(we[n]));
                chk("m_ssel", 32'(s_sel), 32'(sel[n*4 +: 4]));
                chk("m_sadr", s_adr, adr[n*32 +: 32]);
                chk("m_sdat", s_dat, wdat[n*32 +: 32]);
                if (sack) chk("m_rdat", rdat, sdat);
            end
        end
    endtask

    task automatic model_update();
        logic [1:0] r;
        if (!rst_n) begin
            mo_owner = -1; mo_last = 1; mo_stall = 0; mo_err = 1'b0;
        end else if (mo_owner < 0) begin
            r = cyc & stb;
            mo_stall = 0;
            if (r == 2'b11) mo_owner = 1 - mo_last;
            else if (r[0]) mo_owner = 0;
            else if (r[1]) mo_owner = 1;
        end else if (mo_err) begin
            mo_err = 1'b0;
            mo_stall = 0;
            if (!cyc[mo_owner]) begin
                mo_last = mo_owner; mo_owner = -1;
            end
        end else if (!cyc[mo_owner]) begin
            mo_last = mo_owner; mo_owner = -1; mo_stall = 0;
        end else if (stb[mo_owner] && !sack) begin
            mo_stall++;
            if (mo_stall == TMO) begin
                mo_err = 1'b1; mo_stall = 0;
            end
        end else begin
            mo_stall = 0;
        end
    endtask

    task automatic sample();
        #1;
        if (mchk) model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic new_req(input int n);
        we[n]          = 1'($urandom_range(1));
        sel[n*4 +: 4]  = 4'($urandom);
        adr[n*32 +: 32] = $urandom;
        wdat[n*32 +: 32] = $urandom;
    endtask

    typedef struct {
        bit       rst_n;
        bit [1:0] cyc;
        bit [1:0] stb;
        bit       sack;
        bit [1:0] e_grant;
        bit [1:0] e_ack;
        bit       e_stb;
    } vec_t;

    vec_t tbl[16];
    bit   dead;

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[3]  = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[4]  = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1};
        tbl[5]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b10, 2'b00, 1'b1};
        tbl[9]  = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 2'b10, 1'b1};
        tbl[10] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b10, 2'b00, 1'b0};
        tbl[11] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[12] = '{1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[13] = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1};
        tbl[14] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
        tbl[15] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};

        rst_n = 1'b0; cyc = '0; stb = '0; we = 2'b01; sel = 8'hFF;
        adr  = {32'h4000_0010, 32'h3000_0004};
        wdat = {32'h0BAD_F00D, 32'h1234_5678};
        sack = 1'b0; sdat = '0;
        @(negedge clk);
        adv(); adv();
        mchk = 1'b1;

        // Directed table: single m0 write, tie after a grant, back-to-back.
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            cyc   = tbl[i].cyc;
            stb   = tbl[i].stb;
            sack  = tbl[i].sack;
            sdat  = $urandom;
            sample();
            chk($sformatf("t%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            chk($sformatf("t%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
            chk($sformatf("t%0d_stb", i), 32'(s_stb), 32'(tbl[i].e_stb));
            if (i == 0) chk("t0_rdat", rdat, 0);
            adv();
        end

        // Timeout: m0 read, slave never acks.
        we = 2'b00; cyc = 2'b01; stb = 2'b01; sack = 1'b0;
        sample(); adv();
        for (int i = 0; i < TMO; i++) begin
            sample();
            chk("stall_ack", 32'(ack), 0);
            chk("stall_to", 32'(tmo), 0);
            adv();
        end
        sample();
        chk("to_ack", 32'(ack), 32'h1);
        chk("to_dat", rdat, EDAT);
        chk("to_pulse", 32'(tmo), 1);
        chk("to_stb", 32'(s_stb), 0);
        adv();
        cyc = 2'b00; stb = 2'b00;
        sample(); chk("to_once", 32'(tmo), 0); adv();
        sample(); chk("to_idle", 32'(grant), 0); adv();

        // Ack arriving in the final stalled cycle wins.
        cyc = 2'b01; stb = 2'b01;
        sample(); adv();
        for (int i = 0; i < TMO - 1; i++) begin
            sample(); adv();
        end
        sack = 1'b1; sdat = 32'hA5A5_0007;
        sample();
        chk("late_ack", 32'(ack), 32'h1);
        chk("late_dat", rdat, 32'hA5A5_0007);
        chk("late_to", 32'(tmo), 0);
        adv();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        sample(); chk("late_noerr", 32'(tmo), 0); adv();
        sample(); adv();

        // Locked cycle: m1 holds cyc over three beats while m0 waits.
        cyc = 2'b11; stb = 2'b11;
        sample(); adv();
        for (int b = 0; b < 3; b++) begin
            sack = 1'b0;
            sample(); chk("lock_grant", 32'(grant), 32'h2); adv();
            sack = 1'b1; sdat = 32'hA5A5_0000 + 32'(b);
            sample(); chk("lock_ack", 32'(ack), 32'h2); adv();
        end
        sack = 1'b0; cyc = 2'b01; stb = 2'b01;
        sample(); chk("lock_rel", 32'(grant), 32'h2); adv();
        sample(); chk("lock_idle", 32'(grant), 0); adv();
        sack = 1'b1;
        sample();
        chk("lock_m0", 32'(grant), 32'h1);
        chk("lock_m0ack", 32'(ack), 32'h1);
        adv();
        sack = 1'b0; cyc = 2'b00; stb = 2'b00;
        sample(); adv();
        sample(); adv();

        // Reset while m1 is granted and stalled; tie afterwards goes to m0.
        cyc = 2'b11; stb = 2'b11;
        sample(); adv();
        sample(); chk("rst_pre", 32'(grant), 32'h2); adv();
        rst_n = 1'b0;
        sample(); adv();
        rst_n = 1'b1;
        sample();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_sstb", 32'(s_stb), 0);
        chk("rst_ack", 32'(ack), 0);
        adv();
        sample(); chk("rst_tie", 32'(grant), 32'h1); adv();
        cyc = 2'b00; stb = 2'b00;
        sample(); adv();
        sample(); adv();

        // Randomized traffic against the model.
        dead = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!cyc[n]) begin
                    if ($urandom_range(5) == 0) begin
                        cyc[n] = 1'b1; stb[n] = 1'b1; new_req(n);
                    end
                end else if ($urandom_range(31) == 0) begin
                    cyc[n] = 1'b0; stb[n] = 1'b0;
                end else if (exp_ack[n]) begin
                    case ($urandom_range(2))
                        0: begin cyc[n] = 1'b0; stb[n] = 1'b0; end
                        1: stb[n] = 1'b0;
                        default: begin stb[n] = 1'b1; new_req(n); end
                    endcase
                end else if (!stb[n]) begin
                    stb[n] = 1'b1; new_req(n);
                end
            end
            if ($urandom_range(99) == 0) dead = ~dead;
            sack  = !dead && ($urandom_range(3) == 0);
            sdat  = $urandom;
            rst_n = ($urandom_range(499) != 0);
            sample();
            adv();
        end

        cyc = 2'b00; stb = 2'b00; sack = 1'b0; rst_n = 1'b1;
        sample(); adv();
        sample(); adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master to one-slave Wishbone arbiter in front of the user project's Wishbone slave port. Master 0 is the management SoC Wishbone. Master 1 is an LA-driven debug bridge. The block does round-robin arbitration, holds the grant for the whole cyc, and includes a bus-timeout watchdog that terminates hung transfers with an error-data ack. It sits inside user_project_wrapper between the wbs_* pins and the user project.

Parameters:
TIMEOUT, 256, consecutive stalled cycles (s_stb_o=1, s_ack_i=0) that trigger an error termination; legal range 2..65535.
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer.

Ports:
wb_clk_i  in  1  sole clock, rising edge
wb_rst_n_i  in  1  synchronous active-low reset
m_cyc_i  in  2  per-master cyc; bit n = master n
m_stb_i  in  2  per-master stb
m_we_i  in  2  per-master write enable
m_sel_i  in  8  byte selects; [3:0]=m0, [7:4]=m1
m_adr_i  in  64  addresses; [31:0]=m0, [63:32]=m1
m_dat_i  in  64  write data; same packing as m_adr_i
m_ack_o  out  2  per-master ack
m_dat_o  out  32  shared read data; valid only with the matching m_ack_o bit
s_cyc_o  out  1  slave cyc
s_stb_o  out  1  slave stb
s_we_o  out  1  slave we
s_sel_o  out  4  slave sel
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_ack_i  in  1  slave ack
s_dat_i  in  32  slave read data
grant_o  out  2  one-hot current grant; 00 when idle
timeout_o  out  1  one-cycle pulse per timeout event

Behaviour:
- Reset (wb_rst_n_i=0 sampled at an edge):
  - state=IDLE, grant_o=00, last_grant=1 (so m0 wins the first tie), stall counter=0.
  - All s_* outputs 0, m_ack_o=00, m_dat_o=0, timeout_o=0.
  - A reset mid-transfer abandons the transfer; no ack is issued.
- States: IDLE, GRANT, ERR. The granted index g is a register.
- IDLE:
  - s_* outputs and m_ack_o are 0.
  - Request n is m_cyc_i[n] & m_stb_i[n].
  - One requester: g=n, go to GRANT.
  - Both requesting: g = !last_grant.
  - Arbitration latency is one cycle: grant_o is asserted the cycle after the request is first seen.
- GRANT:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o are a combinational mux of master g's signals.
  - m_ack_o[g] = s_ack_i; m_ack_o[!g] = 0; m_dat_o = s_dat_i.
  - Grant is held while m_cyc_i[g]=1, so multi-beat and locked cycles are never interleaved.
  - When m_cyc_i[g]=0: last_grant<=g, go to IDLE.
  - Back-to-back transactions always pass through one IDLE cycle.
  - The ungranted master sees no ack and waits; its stb stays pending.
- Stall counter (16 bit):
  - Clears on s_ack_i, on s_stb_o=0, and on leaving GRANT.
  - Otherwise increments each cycle with s_stb_o=1 and s_ack_i=0.
  - When the counter reaches TIMEOUT-1 while stalled, go to ERR.
  - If s_ack_i arrives in that same cycle, the ack wins and there is no timeout.
- ERR (exactly one cycle):
  - s_cyc_o = s_stb_o = 0.
  - m_ack_o[g]=1, m_dat_o=ERR_DATA, timeout_o=1.
  - Counter cleared.
  - Next state: GRANT if m_cyc_i[g]=1, else IDLE (with last_grant<=g).
- A master dropping cyc mid-wait releases the bus on the next edge; the slave sees cyc fall; no ack is returned.
- Any s_ack_i outside GRANT is ignored.
- Inputs of the ungranted master never affect the s_* outputs.

Test Plan:
- Single m0 write: adr=0x3000_0004, dat=0x1234_5678, sel=F, slave acks 2 cycles after stb → grant_o=01 one cycle after the request; slave sees identical adr/dat/sel/we; m_ack_o=01 for exactly one cycle; then IDLE.
- Simultaneous m0 and m1 reads held continuously, slave returns 0xA5A5_0000+n → service order m0, m1, m0, m1; each master receives only its own acks; one idle cycle between grants.
- Locked cycle: m1 holds cyc for 3 stb/ack beats while m0 requests → m0 is not granted until m1 drops cyc; m0 then completes normally.
- Timeout with TIMEOUT=8: m0 read, slave never acks → after 8 stalled cycles m_ack_o[0]=1 with m_dat_o=0xDEADBEEF; timeout_o pulses once; s_stb_o=0 in that cycle. Also drive s_ack_i in the 8th stalled cycle → normal ack, no timeout pulse.
- Reset mid-transfer: assert wb_rst_n_i=0 while m1 is granted and stalled → next edge grant_o=00, all s_* outputs 0, no ack; after release, a tie is won by m0.
